// File: rtl/gate_tt_checker_pkg.sv
// Shared definitions for the gate truth-table checker: FSM state encoding and
// expected truth tables for the 2-input basic gates, indexed {B,A}.
package gate_tt_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FIN    = 2'd3
  } state_t;

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

  localparam logic [1:0] LAST_IDX = 2'd3;

endpackage

// File: rtl/gate_tt_checker.sv
// Truth-table sequencer: walks {B,A} = 00,01,10,11 into an external 2-input gate,
// samples its X output after a settle delay and scores it against EXP_TT.
module gate_tt_checker
  import gate_tt_checker_pkg::*;
#(
  parameter logic [3:0]  EXP_TT = TT_NAND,
  parameter int unsigned SETTLE = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  input  logic       X,
  output logic       A,
  output logic       B,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [3:0] FAIL_MASK,
  output logic [2:0] ERR_CNT,
  output logic [3:0] CAPT
);

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  state_t     state_r;
  state_t     state_s;
  logic [1:0] idx_r;
  logic [3:0] cnt_r;
  logic [1:0] idx_nxt_s;
  logic       mismatch_s;

  // Case-inequality so an undriven or unknown X scores as a mismatch in simulation.
  assign mismatch_s = (X !== EXP_TT[idx_r]);
  assign idx_nxt_s  = idx_r + 2'd1;

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (START) state_s = ST_SETTLE;
        else       state_s = ST_IDLE;
      end
      ST_SETTLE: begin
        if (cnt_r == SETTLE_M1) state_s = ST_SAMPLE;
        else                    state_s = ST_SETTLE;
      end
      ST_SAMPLE: begin
        if (idx_r == LAST_IDX) state_s = ST_FIN;
        else                   state_s = ST_SETTLE;
      end
      ST_FIN:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register plus BUSY/DONE, registered from the next state so they align with it.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r <= ST_IDLE;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      state_r <= state_s;
      BUSY    <= (state_s == ST_SETTLE) || (state_s == ST_SAMPLE);
      DONE    <= (state_s == ST_FIN);
    end
  end

  // Vector sequencing, settle counting and result capture.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      idx_r     <= 2'd0;
      cnt_r     <= 4'd0;
      A         <= 1'b0;
      B         <= 1'b0;
      PASS      <= 1'b0;
      FAIL_MASK <= 4'b0000;
      ERR_CNT   <= 3'd0;
      CAPT      <= 4'b0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          idx_r <= 2'd0;
          cnt_r <= 4'd0;
          if (START) begin
            A         <= 1'b0;
            B         <= 1'b0;
            PASS      <= 1'b0;
            FAIL_MASK <= 4'b0000;
            ERR_CNT   <= 3'd0;
            CAPT      <= 4'b0000;
          end
        end
        ST_SETTLE: begin
          cnt_r <= cnt_r + 4'd1;
        end
        ST_SAMPLE: begin
          CAPT[idx_r] <= X;
          if (mismatch_s) begin
            FAIL_MASK[idx_r] <= 1'b1;
            ERR_CNT          <= ERR_CNT + 3'd1;
          end
          // A/B only move on entry to the next vector's settle window.
          if (idx_r != LAST_IDX) begin
            idx_r <= idx_nxt_s;
            cnt_r <= 4'd0;
            A     <= idx_nxt_s[0];
            B     <= idx_nxt_s[1];
          end
        end
        ST_FIN: begin
          PASS <= (FAIL_MASK == 4'b0000);
        end
        default: begin
          idx_r <= 2'd0;
          cnt_r <= 4'd0;
        end
      endcase
    end
  end

endmodule
